pc_sequencer: RTL

- Parametrised program-counter sequencer for the RISC fetch stage; successor to the fixed 16-bit, +1-only ripple incrementor.
- Holds the PC register and advances it each cycle by STEP.
- Supports stall, signed relative branch and absolute jump, with a wrap flag, a misalignment flag and a count of sequential advances.
- Feeds instruction-memory address and link-address (PC+STEP) to the decode/JAL path.

---
 rtl/pc_pkg.sv | 32 +++
 rtl/pc_adder.sv | 21 ++
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the fetch-stage program-counter sequencer:
//   - pc_sel_e   : next-PC source select (jump / branch / hold / increment)
//   - step_log2  : log2 of a power-of-two PC step (alignment bit count)
//   - PC_WIDTH / PC_STEP : default PC width and step shared with fetch/decode
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int PC_WIDTH = 16;
    localparam int PC_STEP  = 1;

    typedef enum logic [1:0] {
        SEL_JMP  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_HOLD = 2'd2,
        SEL_INC  = 2'd3
    } pc_sel_e;

    // Number of low PC bits that must be zero for a STEP-aligned address.
    function automatic int step_log2(input longint unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) == value) begin
                result = i;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pc_adder.sv
// ---------------------------------------------------------------------------
// pc_adder
// WIDTH-bit unsigned adder with carry-out; serves both PC+STEP and
// PC+branch-offset (two's-complement offsets wrap naturally mod 2^WIDTH).
// Ports:
//   a, b  : input  [WIDTH-1:0] operands
//   sum   : output [WIDTH-1:0] (a + b) mod 2^WIDTH
//   cout  : output             carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module pc_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter register for the fetch stage. Each cycle the PC is loaded
// from (highest priority first): absolute jump, relative branch, hold on
// stall, or sequential increment by STEP. Redirect targets are forced to
// STEP alignment; a misaligned request raises a one-cycle MISALIGN pulse.
//
// Optional build macro: PC_TRAP_EN
//   defined   : an increment that carries out loads TRAP_VECTOR and pulses trap
//   undefined : the increment wraps modulo 2^WIDTH, trap is tied low
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   stall      : hold PC this cycle (overridden by jmp / br_taken)
//   br_taken   : relative branch request, target pc + br_offset
//   br_offset  : [WIDTH-1:0] two's-complement branch offset
//   jmp        : absolute jump request (wins over br_taken)
//   jmp_addr   : [WIDTH-1:0] jump target
//   pc         : [WIDTH-1:0] registered current PC
//   pc_plus    : [WIDTH-1:0] pc + STEP, combinational (link address)
//   wrap       : pulse, last sequential increment carried out
//   misalign   : pulse, last accepted redirect target had low bits set
//   adv_cnt    : [CNT_WIDTH-1:0] count of sequential increments taken
//   trap       : pulse, increment overflow trapped (PC_TRAP_EN only)
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter int               STEP         = PC_STEP,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               CNT_WIDTH    = 32,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [WIDTH-1:0]     br_offset,
    input  logic                 jmp,
    input  logic [WIDTH-1:0]     jmp_addr,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus,
    output logic                 wrap,
    output logic                 misalign,
    output logic [CNT_WIDTH-1:0] adv_cnt,
    output logic                 trap
);

    localparam int               ALIGN_BITS = step_log2(longint'(STEP));
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LOW_MASK   = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    // Elaboration-time parameter sanity.
    if (WIDTH < 4 || STEP < 1 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
        $error("pc_sequencer: WIDTH must be >= 4 and STEP a power of two");
    end
    if ((RESET_VECTOR & LOW_MASK) != '0 || (TRAP_VECTOR & LOW_MASK) != '0) begin : g_bad_vector
        $error("pc_sequencer: RESET_VECTOR and TRAP_VECTOR must be STEP-aligned");
    end

    pc_sel_e          sel;
    logic [WIDTH-1:0] br_sum;
    logic             br_cout_unused;
    logic             inc_cout;

    logic [WIDTH-1:0] pc_next;
    logic             wrap_next;
    logic             misalign_next;
    logic             trap_next;
    logic             adv_en;

    pc_adder #(.WIDTH(WIDTH)) u_inc_adder (
        .a    (pc),
        .b    (STEP_W),
        .sum  (pc_plus),
        .cout (inc_cout)
    );

    pc_adder #(.WIDTH(WIDTH)) u_br_adder (
        .a    (pc),
        .b    (br_offset),
        .sum  (br_sum),
        .cout (br_cout_unused)
    );

    // Source select; redirects override stall (pipeline flush).
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel = SEL_INC;
        if (jmp) begin
            sel = SEL_JMP;
        end else if (br_taken) begin
            sel = SEL_BR;
        end else if (stall) begin
            sel = SEL_HOLD;
        end
    end

    // Next-state values for the PC, flags and counter enable.
    always_comb begin
        pc_next       = pc;
        wrap_next     = 1'b0;
        misalign_next = 1'b0;
        trap_next     = 1'b0;
        adv_en        = 1'b0;
        unique case (sel)
            SEL_JMP: begin
                pc_next       = jmp_addr & ~LOW_MASK;
                misalign_next = |(jmp_addr & LOW_MASK);
            end
            SEL_BR: begin
                pc_next       = br_sum & ~LOW_MASK;
                misalign_next = |(br_sum & LOW_MASK);
            end
            SEL_HOLD: begin
                pc_next = pc;
            end
            SEL_INC: begin
                pc_next   = pc_plus;
                wrap_next = inc_cout;
                adv_en    = 1'b1;
`ifdef PC_TRAP_EN
                if (inc_cout) begin
                    pc_next   = TRAP_VECTOR;
                    trap_next = 1'b1;
                end
`endif
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_VECTOR;
            wrap     <= 1'b0;
            misalign <= 1'b0;
            adv_cnt  <= '0;
        end else begin
            pc       <= pc_next;
            wrap     <= wrap_next;
            misalign <= misalign_next;
            if (adv_en) begin
                adv_cnt <= adv_cnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef PC_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap <= 1'b0;
        end else begin
            trap <= trap_next;
        end
    end
`else
    assign trap = 1'b0;
    logic trap_next_unused;
    assign trap_next_unused = trap_next;
`endif

endmodule
